// File: rtl/axis_traffic_gen.sv
// AXI-Stream synthetic packet source: fixed-length packets tagged with source, sequence and beat index.
// Define AXIS_TRAFFIC_GEN_LFSR_DEST_EN to pick destinations from an LFSR instead of round-robin.
module axis_traffic_gen #(
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int SEQ_WIDTH   = 16,
  parameter int SRC_ID      = 0,
  parameter int NUM_DESTS   = 16,
  parameter int PKT_LEN     = 4,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                   clk_usr,
  input  logic                   rst_usr_sync,
  input  logic                   enable,
  input  logic [31:0]            num_packets,
  output logic                   axis_tvalid,
  input  logic                   axis_tready,
  output logic [TDATA_WIDTH-1:0] axis_tdata,
  output logic                   axis_tlast,
  output logic [TID_WIDTH-1:0]   axis_tid,
  output logic [TDEST_WIDTH-1:0] axis_tdest,
  output logic [31:0]            pkt_count,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [TDEST_WIDTH-1:0] SRC       = TDEST_WIDTH'(SRC_ID);
  localparam logic [7:0]             LAST_BEAT = 8'(PKT_LEN - 1);

`ifdef AXIS_TRAFFIC_GEN_LFSR_DEST_EN
  localparam int          DSEL_W   = 16;
  localparam logic [15:0] DSEL_RST = 16'hACE1 ^ 16'(SRC_ID);

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] dsel_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [TDEST_WIDTH-1:0] dest_of(input logic [15:0] l);
    logic [TDEST_WIDTH-1:0] d;
    d = TDEST_WIDTH'(l & 16'(NUM_DESTS - 1));
    return (d == SRC) ? (d ^ TDEST_WIDTH'(1)) : d;
  endfunction
`else
  localparam int                     DSEL_W   = TDEST_WIDTH;
  localparam logic [TDEST_WIDTH-1:0] MASK     = TDEST_WIDTH'(NUM_DESTS - 1);
  localparam logic [TDEST_WIDTH-1:0] DSEL_RST = (SRC_ID == 0) ? TDEST_WIDTH'(1) : '0;

  // Round-robin over all tiles, never addressing ourselves
  function automatic logic [TDEST_WIDTH-1:0] dsel_step(input logic [TDEST_WIDTH-1:0] p);
    logic [TDEST_WIDTH-1:0] n;
    n = (p + TDEST_WIDTH'(1)) & MASK;
    if (n == SRC) n = (n + TDEST_WIDTH'(1)) & MASK;
    return n;
  endfunction

  function automatic logic [TDEST_WIDTH-1:0] dest_of(input logic [TDEST_WIDTH-1:0] p);
    return p;
  endfunction
`endif

  function automatic logic [TDATA_WIDTH-1:0] pack(input logic [7:0] b,
                                                  input logic [SEQ_WIDTH-1:0] s,
                                                  input logic [TDEST_WIDTH-1:0] d);
    logic [TDATA_WIDTH-1:0] v;
    v = '0;
    v[7:0]                                  = b;
    v[8 +: SEQ_WIDTH]                       = s;
    v[8 + SEQ_WIDTH +: TDEST_WIDTH]         = SRC;
    v[8 + SEQ_WIDTH + TDEST_WIDTH +: TDEST_WIDTH] = d;
    return v;
  endfunction

  state_t                 state_q, state_d;
  logic [7:0]             beat_q, beat_d;
  logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
  logic [DSEL_W-1:0]      dsel_q, dsel_d;
  logic [31:0]            pcnt_q, pcnt_d;
  logic [31:0]            npkt_q, npkt_d;
  logic [15:0]            gap_q, gap_d;

  logic                   tvalid_q, tlast_q, done_q;
  logic [TDATA_WIDTH-1:0] tdata_q;
  logic [TID_WIDTH-1:0]   tid_q;
  logic [TDEST_WIDTH-1:0] tdest_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    seq_d   = seq_q;
    dsel_d  = dsel_q;
    pcnt_d  = pcnt_q;
    npkt_d  = npkt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d = SEND;
        npkt_d  = num_packets;
      end
      SEND: if (axis_tready) begin
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          pcnt_d = pcnt_q + 32'd1;
          seq_d  = seq_q + SEQ_WIDTH'(1);
          dsel_d = dsel_step(dsel_q);
          if (npkt_q != 32'd0 && pcnt_d == npkt_q) state_d = DONE;
          else if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = 16'(GAP_CYCLES - 1);
          end
          else if (enable) state_d = SEND;
          else state_d = IDLE;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == 16'd0) state_d = enable ? SEND : IDLE;
        else gap_d = gap_q - 16'd1;
      end
      DONE: if (!enable) begin
        state_d = IDLE;
        pcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values, so a stalled beat keeps every field unchanged
  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      seq_q    <= '0;
      dsel_q   <= DSEL_RST;
      pcnt_q   <= '0;
      npkt_q   <= '0;
      gap_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      tdata_q  <= pack(8'd0, '0, dest_of(DSEL_RST));
      tid_q    <= '0;
      tdest_q  <= dest_of(DSEL_RST);
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      seq_q    <= seq_d;
      dsel_q   <= dsel_d;
      pcnt_q   <= pcnt_d;
      npkt_q   <= npkt_d;
      gap_q    <= gap_d;
      tvalid_q <= (state_d == SEND);
      tlast_q  <= (state_d == SEND) && (beat_d == LAST_BEAT);
      done_q   <= (state_d == DONE);
      tdata_q  <= pack(beat_d, seq_d, dest_of(dsel_d));
      tid_q    <= seq_d[TID_WIDTH-1:0];
      tdest_q  <= dest_of(dsel_d);
    end
  end

  assign axis_tvalid = tvalid_q;
  assign axis_tlast  = tlast_q;
  assign axis_tdata  = tdata_q;
  assign axis_tid    = tid_q;
  assign axis_tdest  = tdest_q;
  assign pkt_count   = pcnt_q;
  assign done        = done_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Scoreboard bench for axis_traffic_gen: instance A (src 0, 16 tiles, no gap), instance B (src 5, 8 tiles, gap 2).
module tb_axis_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic         a_rst, a_en, a_tvalid, a_tready, a_tlast, a_done;
  logic [31:0]  a_np, a_pc;
  logic [511:0] a_tdata;
  logic [1:0]   a_tid;
  logic [3:0]   a_tdest;

  logic         b_rst, b_en, b_tvalid, b_tlast, b_done;
  logic         b_tready = 1'b1;
  logic [31:0]  b_np, b_pc;
  logic [63:0]  b_tdata;
  logic [1:0]   b_tid;
  logic [3:0]   b_tdest;

  axis_traffic_gen #(.SRC_ID(0), .NUM_DESTS(16), .PKT_LEN(4), .GAP_CYCLES(0)) dut_a (
    .clk_usr(clk), .rst_usr_sync(a_rst), .enable(a_en), .num_packets(a_np),
    .axis_tvalid(a_tvalid), .axis_tready(a_tready), .axis_tdata(a_tdata), .axis_tlast(a_tlast),
    .axis_tid(a_tid), .axis_tdest(a_tdest), .pkt_count(a_pc), .done(a_done));

  axis_traffic_gen #(.TDATA_WIDTH(64), .SRC_ID(5), .NUM_DESTS(8), .PKT_LEN(2), .GAP_CYCLES(2)) dut_b (
    .clk_usr(clk), .rst_usr_sync(b_rst), .enable(b_en), .num_packets(b_np),
    .axis_tvalid(b_tvalid), .axis_tready(b_tready), .axis_tdata(b_tdata), .axis_tlast(b_tlast),
    .axis_tid(b_tid), .axis_tdest(b_tdest), .pkt_count(b_pc), .done(b_done));

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [1:0]   tid;
    logic [3:0]   dest;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  function automatic beat_t mk(input int src, input int seq, input int dest, input int beat, input int plen);
    beat_t e;
    e.data        = '0;
    e.data[7:0]   = 8'(beat);
    e.data[23:8]  = 16'(seq);
    e.data[27:24] = 4'(src);
    e.data[31:28] = 4'(dest);
    e.last        = (beat == plen - 1);
    e.tid         = 2'(seq);
    e.dest        = 4'(dest);
    return e;
  endfunction

  task automatic push_pkt(input bit to_b, input int src, input int seq, input int dest,
                          input int nbeats, input int plen);
    for (int i = 0; i < nbeats; i++) begin
      if (to_b) qb.push_back(mk(src, seq, dest, i, plen));
      else      qa.push_back(mk(src, seq, dest, i, plen));
    end
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected beats on every handshake, checks stall stability and gap length
  beat_t        ea, eb;
  bit           a_stall = 1'b0;
  logic [511:0] s_data;
  logic         s_last;
  logic [1:0]   s_tid;
  logic [3:0]   s_dest;
  int           a_tail_cyc = -10;
  int           a_hs[$];
  bit           b_tail = 1'b0;
  int           b_idle = 0;

  always @(negedge clk) begin
    if (a_rst) begin
      a_stall = 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_stall_tvalid", a_tvalid, 1);
        chk("a_stall_tdata", a_tdata, s_data);
        chk("a_stall_tlast", a_tlast, s_last);
        chk("a_stall_tid", a_tid, s_tid);
        chk("a_stall_tdest", a_tdest, s_dest);
      end
      if (a_tvalid && a_tready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_unexpected_beat: got tdata %0h, expected no beat", a_tdata);
        end else begin
          ea = qa.pop_front();
          chk("a_tdata", a_tdata, ea.data);
          chk("a_tlast", a_tlast, ea.last);
          chk("a_tid", a_tid, ea.tid);
          chk("a_tdest", a_tdest, ea.dest);
        end
        a_hs.push_back(cyc);
        if (a_tlast) a_tail_cyc = cyc;
      end
      a_stall = a_tvalid && !a_tready;
      s_data = a_tdata; s_last = a_tlast; s_tid = a_tid; s_dest = a_tdest;
    end
    if (!b_rst) begin
      if (b_tvalid) begin
        if (b_tail) chk("b_gap_cycles", b_idle, 2);
        b_tail = 1'b0;
      end else if (b_tail) begin
        b_idle++;
      end
      if (b_tvalid && b_tready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected_beat: got tdata %0h, expected no beat", b_tdata);
        end else begin
          eb = qb.pop_front();
          chk("b_tdata", {448'b0, b_tdata}, eb.data);
          chk("b_tlast", b_tlast, eb.last);
          chk("b_tid", b_tid, eb.tid);
          chk("b_tdest", b_tdest, eb.dest);
        end
        chk("b_tdest_not_src", b_tdest != 4'd5, 1);
        if (b_tlast) begin
          b_tail = 1'b1;
          b_idle = 0;
        end
      end
    end
  end

  bit pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};
  int bd[16] = '{0, 1, 2, 3, 4, 6, 7, 0, 1, 2, 3, 4, 6, 7, 0, 1};

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_np = '0; a_tready = 1'b1;
    b_rst = 1'b1; b_en = 1'b0; b_np = '0;
    repeat (3) step();
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    // reset state
    chk("rst_a_tvalid", a_tvalid, 0);
    chk("rst_a_tlast", a_tlast, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_pkt_count", a_pc, 0);
    chk("rst_a_tdata", a_tdata, mk(0, 0, 1, 0, 4).data);
    chk("rst_a_tdest", a_tdest, 1);
    chk("rst_a_tid", a_tid, 0);
    chk("rst_b_tvalid", b_tvalid, 0);
    chk("rst_b_tdest", b_tdest, 0);

    // three back-to-back packets, dest 1,2,3
    a_hs.delete();
    for (int p = 0; p < 3; p++) push_pkt(0, 0, p, p + 1, 4, 4);
    a_np = 32'd3; a_en = 1'b1;
    for (int i = 0; i < 40 && !a_done; i++) step();
    chk("t1_done", a_done, 1);
    chk("t1_done_latency", cyc, a_tail_cyc + 1);
    chk("t1_beat_count", a_hs.size(), 12);
    if (a_hs.size() == 12) chk("t1_no_bubble", a_hs[11] - a_hs[0], 11);
    chk("t1_pkt_count", a_pc, 3);
    chk("t1_queue_empty", qa.size(), 0);
    chk("t1_tvalid_in_done", a_tvalid, 0);
    a_en = 1'b0;
    step();
    chk("t1_done_clear", a_done, 0);
    chk("t1_pkt_count_clear", a_pc, 0);

    // backpressure during one packet
    push_pkt(0, 0, 3, 4, 4, 4);
    a_np = 32'd1; a_en = 1'b1;
    for (int i = 0; i < 5 && !a_tvalid; i++) step();
    chk("t2_tvalid_up", a_tvalid, 1);
    for (int i = 0; i < 8; i++) begin
      a_tready = pat[i];
      step();
    end
    a_tready = 1'b1;
    for (int i = 0; i < 10 && !a_done; i++) step();
    chk("t2_done", a_done, 1);
    chk("t2_pkt_count", a_pc, 1);
    chk("t2_queue_empty", qa.size(), 0);
    a_en = 1'b0;
    step();

    // enable dropped at beat 1: packet completes, then idle
    push_pkt(0, 0, 4, 5, 4, 4);
    a_np = 32'd0; a_en = 1'b1;
    for (int i = 0; i < 10 && !(a_tvalid && a_tdata[7:0] == 8'd1); i++) step();
    chk("t5_at_beat1", a_tdata[7:0], 1);
    a_en = 1'b0;
    repeat (6) step();
    chk("t5_tvalid_idle", a_tvalid, 0);
    chk("t5_queue_empty", qa.size(), 0);
    chk("t5_pkt_count_hold", a_pc, 1);
    chk("t5_done", a_done, 0);

    // reset at beat 2, then a fresh run starts from seq 0, dest 1
    push_pkt(0, 0, 5, 6, 2, 4);
    a_en = 1'b1;
    for (int i = 0; i < 10 && !(a_tvalid && a_tdata[7:0] == 8'd2); i++) step();
    chk("t6_at_beat2", a_tdata[7:0], 2);
    a_rst = 1'b1;
    step();
    chk("t6_tvalid_drop", a_tvalid, 0);
    a_rst = 1'b0; a_en = 1'b0;
    step();
    chk("t6_queue_empty", qa.size(), 0);
    chk("t6_tdata_reset", a_tdata, mk(0, 0, 1, 0, 4).data);
    chk("t6_pkt_count_reset", a_pc, 0);
    push_pkt(0, 0, 0, 1, 4, 4);
    a_np = 32'd1; a_en = 1'b1;
    for (int i = 0; i < 20 && !a_done; i++) step();
    chk("t6_done", a_done, 1);
    chk("t6_queue_empty2", qa.size(), 0);
    a_en = 1'b0;
    step();

    // instance B: 16 packets with 2-cycle gaps, destinations skip tile 5
    for (int p = 0; p < 16; p++) push_pkt(1, 5, p, bd[p], 2, 2);
    b_np = 32'd16; b_en = 1'b1;
    for (int i = 0; i < 200 && !b_done; i++) step();
    chk("b_done", b_done, 1);
    chk("b_pkt_count", b_pc, 16);
    chk("b_queue_empty", qb.size(), 0);
    b_en = 1'b0;
    step();
    chk("b_done_clear", b_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
